// File: rtl/arm_pipe_pkg.sv
// Shared types and constants for the ARM pipeline control slice.
package arm_pipe_pkg;
    localparam int REG_IDX_W = 4;
    localparam int CNT_W_DEF = 16;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } ctrl_state_e;

    typedef enum logic [1:0] {
        MODE_NORMAL = 2'd0,
        MODE_STALL  = 2'd1,
        MODE_FLUSH  = 2'd2,
        MODE_FREEZE = 2'd3
    } ctrl_mode_e;
endpackage

// File: rtl/pipeline_controller_hazard_detect.sv
// Register-match hazard detection between ID sources and EXE/MEM destinations.
// FORWARD_EN: only load-use against EXE raises a hazard; otherwise all EXE/MEM matches do.
module hazard_detect
    import arm_pipe_pkg::*;
(
    input  logic [REG_IDX_W-1:0] id_src1,
    input  logic [REG_IDX_W-1:0] id_src2,
    input  logic                 id_two_src,
    input  logic                 id_use_src1,
    input  logic [REG_IDX_W-1:0] exe_dest,
    input  logic                 exe_wb_en,
    input  logic                 exe_mem_r_en,
    input  logic [REG_IDX_W-1:0] mem_dest,
    input  logic                 mem_wb_en,
    output logic                 hazard
);
    logic src1_exe, src2_exe, src1_mem, src2_mem;

    assign src1_exe = id_use_src1 && (id_src1 == exe_dest);
    assign src2_exe = id_two_src  && (id_src2 == exe_dest);
    assign src1_mem = id_use_src1 && (id_src1 == mem_dest);
    assign src2_mem = id_two_src  && (id_src2 == mem_dest);

`ifdef FORWARD_EN
    // ALU results are forwarded, so only a load still in EXE forces a bubble.
    logic unused_fwd;
    assign unused_fwd = ^{exe_wb_en, mem_wb_en, src1_mem, src2_mem};
    assign hazard = exe_mem_r_en && (src1_exe || src2_exe);
`else
    logic unused_nofwd;
    assign unused_nofwd = exe_mem_r_en;
    assign hazard = (exe_wb_en && (src1_exe || src2_exe)) ||
                    (mem_wb_en && (src1_mem || src2_mem));
`endif
endmodule

// File: rtl/pipeline_controller.sv
// Stall/flush sequencer for the five-stage pipeline: FSM, priority mux, saturating counters.
// Optional macro FORWARD_EN (see hazard_detect). The MEM-stage writeback input is
// named mem_stage_wb_en to keep it apart from the MEM/WB register enable output.
module pipeline_controller
    import arm_pipe_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_IDX_W-1:0] id_src1,
    input  logic [REG_IDX_W-1:0] id_src2,
    input  logic                 id_two_src,
    input  logic                 id_use_src1,
    input  logic [REG_IDX_W-1:0] exe_dest,
    input  logic                 exe_wb_en,
    input  logic                 exe_mem_r_en,
    input  logic [REG_IDX_W-1:0] mem_dest,
    input  logic                 mem_stage_wb_en,
    input  logic                 exe_branch,
    input  logic                 mem_req,
    input  logic                 mem_ready,
    output logic                 pc_en,
    output logic                 if_id_en,
    output logic                 if_id_clr,
    output logic                 id_exe_en,
    output logic                 id_exe_clr,
    output logic                 exe_mem_en,
    output logic                 mem_wb_en,
    output logic                 mem_wb_clr,
    output logic                 in_mem_wait,
    output logic [CNT_W-1:0]     stall_count,
    output logic [CNT_W-1:0]     flush_count
);
    ctrl_state_e      state_q, state_d;
    ctrl_mode_e       mode;
    logic             hazard, freeze;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    hazard_detect u_hazard (
        .id_src1      (id_src1),
        .id_src2      (id_src2),
        .id_two_src   (id_two_src),
        .id_use_src1  (id_use_src1),
        .exe_dest     (exe_dest),
        .exe_wb_en    (exe_wb_en),
        .exe_mem_r_en (exe_mem_r_en),
        .mem_dest     (mem_dest),
        .mem_wb_en    (mem_stage_wb_en),
        .hazard       (hazard)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RUN;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:      if (mem_req && !mem_ready) state_d = MEM_WAIT;
            MEM_WAIT: if (mem_ready)             state_d = RUN;
            default:                             state_d = RUN;
        endcase
    end

    // A held branch loses to the freeze and is flushed once mem_ready arrives.
    assign freeze = (state_q == RUN && mem_req && !mem_ready) ||
                    (state_q == MEM_WAIT && !mem_ready);

    always_comb begin
        if (freeze)          mode = MODE_FREEZE;
        else if (exe_branch) mode = MODE_FLUSH;
        else if (hazard)     mode = MODE_STALL;
        else                 mode = MODE_NORMAL;
    end

    always_comb begin
        pc_en      = 1'b1;
        if_id_en   = 1'b1;
        if_id_clr  = 1'b0;
        id_exe_en  = 1'b1;
        id_exe_clr = 1'b0;
        exe_mem_en = 1'b1;
        mem_wb_en  = 1'b1;
        mem_wb_clr = 1'b0;
        if (!rst) begin
            pc_en      = 1'b0;
            if_id_en   = 1'b0;
            id_exe_en  = 1'b0;
            exe_mem_en = 1'b0;
            mem_wb_en  = 1'b0;
            if_id_clr  = 1'b1;
            id_exe_clr = 1'b1;
            mem_wb_clr = 1'b1;
        end else begin
            case (mode)
                MODE_FREEZE: begin
                    pc_en      = 1'b0;
                    if_id_en   = 1'b0;
                    id_exe_en  = 1'b0;
                    exe_mem_en = 1'b0;
                    mem_wb_en  = 1'b0;
                    mem_wb_clr = 1'b1;
                end
                MODE_FLUSH: begin
                    if_id_clr  = 1'b1;
                    id_exe_clr = 1'b1;
                end
                MODE_STALL: begin
                    pc_en      = 1'b0;
                    if_id_en   = 1'b0;
                    id_exe_clr = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if ((mode == MODE_FREEZE || mode == MODE_STALL) && stall_cnt_q != '1)
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (mode == MODE_FLUSH && flush_cnt_q != '1)
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    assign in_mem_wait = (state_q == MEM_WAIT);
    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;
endmodule

// File: doc/pipeline_controller.md
# pipeline_controller

Central stall/flush sequencer for the five-stage ARM pipeline. Each cycle it drives the enable/clear pair of every inter-stage register (IF/ID, ID/EXE, EXE/MEM, MEM/WB) and the PC enable. It resolves three event types: data hazards detected in ID, taken branches resolved in EXE, and multi-cycle SRAM accesses in MEM. It also keeps saturating stall and flush counters for performance debug.

## Interface
- CNT_W, 16, width of the stall and flush counters
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-low reset
- id_src1  in  4  Rn index of the instruction in ID
- id_src2  in  4  Rm/Rd index of the instruction in ID
- id_two_src  in  1  ID instruction reads id_src2
- id_use_src1  in  1  ID instruction reads id_src1
- exe_dest  in  4  destination register in EXE
- exe_wb_en  in  1  EXE instruction writes back
- exe_mem_r_en  in  1  EXE instruction is a load
- mem_dest  in  4  destination register in MEM
- mem_wb_en  in  1  MEM instruction writes back
- exe_branch  in  1  taken branch resolved in EXE
- mem_req  in  1  MEM stage is accessing SRAM (read or write)
- mem_ready  in  1  SRAM controller completes the access this cycle
- pc_en  out  1  PC register enable
- if_id_en, if_id_clr  out  1 each  IF/ID register controls
- id_exe_en, id_exe_clr  out  1 each  ID/EXE register controls
- exe_mem_en  out  1  EXE/MEM register enable
- mem_wb_en, mem_wb_clr  out  1 each  MEM/WB register controls
- in_mem_wait  out  1  FSM is in MEM_WAIT
- stall_count  out  CNT_W  cycles with a hazard stall or mem freeze
- flush_count  out  CNT_W  branch flushes applied

## Operation
- FSM states: RUN, MEM_WAIT. Reset state: RUN.
- RUN → MEM_WAIT when mem_req=1 and mem_ready=0. MEM_WAIT → RUN on mem_ready=1.
- Hazard (combinational): a match requires a nonzero-enable source equal to exe_dest with exe_wb_en=1, or equal to mem_dest with mem_wb_en=1. id_src2 is considered only when id_two_src=1, and id_src1 only when id_use_src1=1.
- Priority, highest first:
  1. Memory freeze: (RUN with mem_req & !mem_ready) or (MEM_WAIT & !mem_ready).
  2. Branch flush: exe_branch=1.
  3. Hazard stall.
  4. Normal.
- Memory freeze: pc_en, if_id_en, id_exe_en, exe_mem_en and mem_wb_en are 0. mem_wb_clr=1, which gives WB a bubble so there is no repeated writeback. All other clears are 0.
- Branch flush: all enables 1, if_id_clr=1, id_exe_clr=1. Any hazard is ignored.
  - A branch held during MEM_WAIT is flushed in the cycle mem_ready=1.
- Hazard stall: pc_en=0, if_id_en=0, id_exe_clr=1. All other enables 1.
- Normal: all enables 1, all clears 0.
- Counters:
  - stall_count increments in each memory-freeze or hazard-stall cycle.
  - flush_count increments in each branch-flush cycle.
  - Both saturate at all-ones and never wrap.

## Timing
- All control outputs are combinational from the FSM state and the current inputs, so they act in the same cycle. Only the state and the counters are registered.
- While rst=0: state=RUN, counters=0, all enables 0, if_id_clr/id_exe_clr/mem_wb_clr=1, in_mem_wait=0.
- A reset asserted mid-wait returns the FSM to RUN immediately and asynchronously.
- Load-use costs exactly 1 stall cycle when FORWARD_EN is defined.
- An SRAM access with N wait cycles freezes the pipeline for N cycles. in_mem_wait is 1 from the second freeze cycle through the cycle mem_ready rises.
- mem_ready=1 in RUN with mem_req=1 means a zero-wait access: no freeze.
- mem_ready outside a request is ignored.

## Configuration
- FORWARD_EN defined: the forwarding unit handles ALU results, so a hazard is raised only for exe_mem_r_en=1 with a source matching exe_dest (load-use). MEM-stage matches never stall.
- FORWARD_EN undefined: the full hazard rule above applies, covering EXE and MEM matches.

## Structure
- Package arm_pipe_pkg holds:
  - the state enum (RUN, MEM_WAIT);
  - REG_IDX_W=4;
  - the default CNT_W.
- Sub-module hazard_detect holds the register-match logic and the FORWARD_EN selection. It takes the source/destination inputs and outputs a 1-bit hazard.
- pipeline_controller contains only the FSM, the priority mux and the counters.

## Test plan
- Reset: rst=0 mid-MEM_WAIT → in_mem_wait=0, counters 0, all enables 0, clears 1. Release → normal controls.
- Load-use: exe_mem_r_en=1, exe_wb_en=1, exe_dest=3, id_src1=3, id_use_src1=1 → one cycle of pc_en=0, if_id_en=0, id_exe_clr=1; stall_count=1.
- Without FORWARD_EN: mem_wb_en=1, mem_dest=5, id_two_src=1, id_src2=5 → stall. With FORWARD_EN the same stimulus → no stall.
- Branch plus hazard in the same cycle: exe_branch=1 → if_id_clr=id_exe_clr=1, pc_en=1; flush_count=1; stall_count unchanged.
- SRAM: mem_req=1 with mem_ready low for 3 cycles → 3 freeze cycles (mem_wb_clr=1), in_mem_wait high for cycles 2–4, stall_count=3. An exe_branch held throughout is flushed in the mem_ready cycle.
- Saturation: CNT_W=4, hold the hazard for 20 cycles → stall_count stops at 15.
